piton_aws_axi_err_responder: RTL and testbench

AXI4 slave endpoint that terminates every transaction routed to it with a DECERR response. It sits behind the AXI4 address-translation and decode stage on the AWS shell side, so stray or out-of-window accesses from the Piton NoC-to-AXI4 bridge complete cleanly instead of hanging the interconnect. It honours full burst semantics: it drains all write beats before issuing B, and returns exactly arlen+1 read beats with rlast.

---
 rtl/piton_aws_err_pkg.sv | 18 +
 rtl/piton_aws_err_rd_beat_gen.sv | 68 ++++++
 rtl/piton_aws_axi_err_responder.sv | 164 ++++++++++++++++
 tb/tb_piton_aws_axi_err_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piton_aws_err_pkg.sv
// Shared constants and FSM state types for the AXI4 DECERR responder.
package piton_aws_err_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DRAIN = 2'd1,
    W_RESP  = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/piton_aws_err_rd_beat_gen.sv
// Read-side FSM: accepts one AR, then returns arlen+1 DECERR beats with rlast.
module piton_aws_err_rd_beat_gen
  import piton_aws_err_pkg::*;
#(
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_DATA_WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [AXI4_ID_WIDTH-1:0]   arid,
  input  logic [7:0]                 arlen,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [AXI4_ID_WIDTH-1:0]   rid,
  output logic [AXI4_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                 rresp,
  output logic                       rlast,
  output logic                       rvalid,
  input  logic                       rready
);

  r_state_t                   state_q, state_d;
  logic [AXI4_ID_WIDTH-1:0]   id_q;
  logic [7:0]                 len_q;
  logic [7:0]                 beat_q;
  logic                       ar_hs;
  logic                       r_hs;

  assign arready = en && (state_q == R_IDLE);
  assign rvalid  = (state_q == R_DATA);
  assign rid     = id_q;
  assign rdata   = '0;
  assign rresp   = rvalid ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  // beat_q never exceeds len_q, so an arlen of 255 reaches rlast without wrapping
  assign rlast   = rvalid && (beat_q == len_q);

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (ar_hs) state_d = R_DATA;
      R_DATA:  if (r_hs && rlast) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        id_q   <= arid;
        len_q  <= arlen;
        beat_q <= '0;
      end else if (r_hs && !rlast) begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/piton_aws_axi_err_responder.sv
// AXI4 slave that completes every transaction with DECERR.
// Optional error statistics enabled by defining PITON_AWS_ERR_RESP_STATS_EN.
module piton_aws_axi_err_responder
  import piton_aws_err_pkg::*;
#(
  parameter int AXI4_ADDR_WIDTH = 64,
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_DATA_WIDTH = 512,
  parameter int STATS_CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [AXI4_ID_WIDTH-1:0]     awid,
  input  logic [AXI4_ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]                   awlen,
  input  logic                         awvalid,
  output logic                         awready,

  input  logic [AXI4_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI4_DATA_WIDTH/8-1:0] wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,

  output logic [AXI4_ID_WIDTH-1:0]     bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,

  input  logic [AXI4_ID_WIDTH-1:0]     arid,
  input  logic [AXI4_ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]                   arlen,
  input  logic                         arvalid,
  output logic                         arready,

  output logic [AXI4_ID_WIDTH-1:0]     rid,
  output logic [AXI4_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,

  output logic                         buser,
  output logic                         ruser
`ifdef PITON_AWS_ERR_RESP_STATS_EN
  ,
  input  logic                         err_clr,
  output logic [STATS_CNT_WIDTH-1:0]   err_wr_cnt,
  output logic [STATS_CNT_WIDTH-1:0]   err_rd_cnt,
  output logic [AXI4_ADDR_WIDTH-1:0]   err_addr,
  output logic                         err_addr_vld
`endif
);

  w_state_t                 w_state_q, w_state_d;
  logic [AXI4_ID_WIDTH-1:0] bid_q;
  logic                     rdy_q;
  logic                     aw_hs;
  logic                     w_last_hs;
  logic                     b_hs;
  logic                     ar_hs;
  logic                     r_last_hs;

  assign buser = 1'b0;
  assign ruser = 1'b0;

  // rdy_q holds the ready outputs low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  assign awready   = rdy_q && (w_state_q == W_IDLE);
  assign wready    = (w_state_q == W_DRAIN);
  assign bvalid    = (w_state_q == W_RESP);
  assign bid       = bid_q;
  assign bresp     = bvalid ? AXI_RESP_DECERR : AXI_RESP_OKAY;

  assign aw_hs     = awvalid && awready;
  assign w_last_hs = wvalid && wready && wlast;
  assign b_hs      = bvalid && bready;

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DRAIN;
      W_DRAIN: if (w_last_hs) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) bid_q <= awid;
    end
  end

  piton_aws_err_rd_beat_gen #(
    .AXI4_ID_WIDTH   (AXI4_ID_WIDTH),
    .AXI4_DATA_WIDTH (AXI4_DATA_WIDTH)
  ) u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rdy_q),
    .arid    (arid),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  assign ar_hs     = arvalid && arready;
  assign r_last_hs = rvalid && rready && rlast;

`ifdef PITON_AWS_ERR_RESP_STATS_EN
  logic [STATS_CNT_WIDTH-1:0] wr_cnt_q, rd_cnt_q;
  logic [AXI4_ADDR_WIDTH-1:0] addr_q;
  logic                       addr_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
    end else if (err_clr) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
    end else begin
      if (b_hs && (wr_cnt_q != '1))      wr_cnt_q <= wr_cnt_q + 1'b1;
      if (r_last_hs && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (!addr_vld_q && (aw_hs || ar_hs)) begin
        addr_q     <= aw_hs ? awaddr : araddr;
        addr_vld_q <= 1'b1;
      end
    end
  end

  assign err_wr_cnt   = wr_cnt_q;
  assign err_rd_cnt   = rd_cnt_q;
  assign err_addr     = addr_q;
  assign err_addr_vld = addr_vld_q;

  logic unused_inputs;
  assign unused_inputs = ^{awlen, wdata, wstrb};
`else
  logic unused_inputs;
  assign unused_inputs = ^{awaddr, awlen, wdata, wstrb, araddr, b_hs, r_last_hs, ar_hs};
`endif

endmodule

// File: tb/tb_piton_aws_axi_err_responder.sv
// Directed self-checking bench for piton_aws_axi_err_responder.
// Stats checks run when PITON_AWS_ERR_RESP_STATS_EN is defined.
module tb_piton_aws_axi_err_responder;

  localparam int AW = 64;
  localparam int IW = 16;
  localparam int DW = 512;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IW-1:0]   awid, arid;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic            awvalid, awready, wlast, wvalid, wready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [IW-1:0]   bid, rid;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  logic            buser, ruser;
`ifdef PITON_AWS_ERR_RESP_STATS_EN
  logic            err_clr;
  logic [CW-1:0]   err_wr_cnt, err_rd_cnt;
  logic [AW-1:0]   err_addr;
  logic            err_addr_vld;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piton_aws_axi_err_responder #(
    .AXI4_ADDR_WIDTH (AW),
    .AXI4_ID_WIDTH   (IW),
    .AXI4_DATA_WIDTH (DW),
    .STATS_CNT_WIDTH (CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .buser(buser), .ruser(ruser)
`ifdef PITON_AWS_ERR_RESP_STATS_EN
    ,
    .err_clr(err_clr), .err_wr_cnt(err_wr_cnt), .err_rd_cnt(err_rd_cnt),
    .err_addr(err_addr), .err_addr_vld(err_addr_vld)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef PITON_AWS_ERR_RESP_STATS_EN
  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr);
    awid = id; awaddr = addr; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr);
    arid = id; araddr = addr; arlen = 8'd0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask
`endif

  initial begin
    int beats;
    bit done;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
`ifdef PITON_AWS_ERR_RESP_STATS_EN
    err_clr = 1'b0;
`endif

    // Reset values
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready",  wready,  0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_bid",     bid,     0);
    chk("rst_rid",     rid,     0);
    chk("rst_bresp",   bresp,   0);
    chk("rst_rresp",   rresp,   0);
    chk("rst_rlast",   rlast,   0);
    chk("rst_rdata",   rdata,   0);
    rst_n = 1'b1;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);

    // Early wvalid must not be accepted in W_IDLE
    wvalid = 1'b1; wdata = {DW{1'b1}}; wstrb = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("early_wready", wready, 0);
    end
    awid = 16'h5; awaddr = 64'h100; awlen = 8'd3; awvalid = 1'b1;
    tick();
    chk("aw_awready", awready, 0);
    chk("aw_wready",  wready,  1);
    awvalid = 1'b0;
    tick(); tick(); tick();
    chk("w3_bvalid", bvalid, 0);
    chk("w3_wready", wready, 1);
    wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_bvalid", bvalid, 1);
    chk("b_bid",    bid,    16'h5);
    chk("b_bresp",  bresp,  2'b11);
    chk("b_wready", wready, 0);
    tick();
    chk("bhold_bvalid", bvalid, 1);
    chk("bhold_bid",    bid,    16'h5);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bdone_bvalid",  bvalid,  0);
    chk("bdone_awready", awready, 1);

    // arlen=7 with rready held high
    arid = 16'hA; araddr = 64'h200; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("ar_arready", arready, 0);
    for (int i = 0; i < 8; i++) begin
      chk("r8_rvalid", rvalid, 1);
      chk("r8_rid",    rid,    16'hA);
      chk("r8_rdata",  rdata,  0);
      chk("r8_rresp",  rresp,  2'b11);
      chk("r8_rlast",  rlast,  (i == 7));
      tick();
    end
    chk("r8_end_rvalid",  rvalid,  0);
    chk("r8_end_arready", arready, 1);

    // arlen=255 with rready toggling
    arid = 16'h3C; arlen = 8'd255; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    beats = 0;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      rready = c[0];
      chk("r256_rvalid", rvalid, 1);
      chk("r256_rid",    rid,    16'h3C);
      chk("r256_rlast",  rlast,  (beats == 255));
      if (rready) begin
        beats++;
        if (beats == 256) done = 1'b1;
      end
      tick();
    end
    rready = 1'b0;
    chk("r256_beats",   beats,   256);
    chk("r256_rvalid0", rvalid,  0);
    chk("r256_arready", arready, 1);

    // Simultaneous AW and AR
    awid = 16'h7; awlen = 8'd0; awvalid = 1'b1;
    arid = 16'h9; arlen = 8'd0; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("dual_awready", awready, 0);
    chk("dual_arready", arready, 0);
    chk("dual_wready",  wready,  1);
    chk("dual_rvalid",  rvalid,  1);
    chk("dual_rlast",   rlast,   1);
    chk("dual_rid",     rid,     16'h9);
    rready = 1'b1; wvalid = 1'b1; wlast = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    chk("dual_rvalid0", rvalid, 0);
    chk("dual_bvalid",  bvalid, 1);
    chk("dual_bid",     bid,    16'h7);
    tick();
    bready = 1'b0;
    chk("dual_bvalid0", bvalid,  0);
    chk("dual_awready1", awready, 1);
    chk("dual_arready1", arready, 1);

    // Reset during beat 3 of an arlen=7 read
    arid = 16'h3; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    tick(); tick();
    chk("mid_rlast", rlast, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid",  rvalid,  0);
    chk("mid_rst_arready", arready, 0);
    rready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_arready", arready, 1);
    chk("mid_rel_rvalid",  rvalid,  0);

`ifdef PITON_AWS_ERR_RESP_STATS_EN
    chk("st_rst_wr",  err_wr_cnt,   0);
    chk("st_rst_vld", err_addr_vld, 0);
    do_write(16'h1, 64'hfff0001000);
    do_write(16'h2, 64'h10);
    do_read(16'h4, 64'h20);
    chk("st_wr_cnt",   err_wr_cnt,   2);
    chk("st_rd_cnt",   err_rd_cnt,   1);
    chk("st_addr",     err_addr,     64'hfff0001000);
    chk("st_addr_vld", err_addr_vld, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("st_clr_wr",   err_wr_cnt,   0);
    chk("st_clr_rd",   err_rd_cnt,   0);
    chk("st_clr_addr", err_addr,     0);
    chk("st_clr_vld",  err_addr_vld, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
